weighted_mean_packer: RTL and testbench

Producer-side front end for weighted_mean. It accepts (sample, weight) pairs serially with a valid/ready handshake and packs N_INPUT pairs into the packed `in`/`weight` buses that weighted_mean consumes. It presents each completed frame with its own valid/ready handshake and an accumulated weight sum. It replaces the free-running counter stimulus with a flow-controlled source, so frames can be supplied from a stream in both the bench and the system.

---
 rtl/weighted_mean_packer.sv | 166 ++++++++++++++++
 tb/tb_weighted_mean_packer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_mean_packer.sv
// weighted_mean_packer
// Serial (sample, weight) front end for weighted_mean. It collects N_INPUT pairs
// into one frame, with the first pair in the MSB slot. A frame closes when the
// last slot fills or when a pair arrives with s_last set; a frame closed by
// s_last is zero-padded. Each closed frame is passed to a registered output
// stage that has its own valid/ready handshake.
// There are two stages: the fill stage (slots, index, running weight sum) and
// the output stage (m_* registers). While the output stage is stalled, the fill
// stage can complete the next frame.

module weighted_mean_packer #(
  parameter int N_INPUT = 4,
  parameter int SIZE    = 32,
  parameter int WS_W    = SIZE + $clog2(N_INPUT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [SIZE-1:0]           s_sample,
  input  logic [SIZE-1:0]           s_weight,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [N_INPUT*SIZE-1:0]   m_in,
  output logic [N_INPUT*SIZE-1:0]   m_weight,
  output logic [WS_W-1:0]           m_wsum,
  output logic                      m_padded,
  output logic [15:0]               frame_cnt
);

  localparam int              IDX_W    = $clog2(N_INPUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUT - 1);

  // fill stage state
  logic [SIZE-1:0]          slot_in_r [N_INPUT];
  logic [SIZE-1:0]          slot_w_r  [N_INPUT];
  logic [IDX_W-1:0]         idx_r;
  logic [WS_W-1:0]          sum_r;
  logic                     fill_done_r;
  logic                     pad_r;
  logic                     s_ready_r;

  // handshake decode and packed view of the slots
  logic                     accept_s;
  logic                     close_s;
  logic                     xfer_s;
  logic                     fill_done_nxt_s;
  logic [N_INPUT*SIZE-1:0]  pack_in_s;
  logic [N_INPUT*SIZE-1:0]  pack_w_s;

  assign s_ready = s_ready_r;

  // Decode accept/close/transfer and the next fill_done value that drives s_ready.
  always_comb begin
    accept_s        = s_valid && s_ready_r;
    close_s         = accept_s && (s_last || (idx_r == LAST_IDX));
    xfer_s          = fill_done_r && (!m_valid || m_ready);
    fill_done_nxt_s = fill_done_r;
    if (xfer_s) begin
      fill_done_nxt_s = 1'b0;
    end else if (close_s) begin
      fill_done_nxt_s = 1'b1;
    end else begin
      fill_done_nxt_s = fill_done_r;
    end
  end

  // Pack the slot registers so that slot 0 lands in the MSB position.
  always_comb begin
    pack_in_s = '0;
    pack_w_s  = '0;
    for (int i = 0; i < N_INPUT; i++) begin
      pack_in_s[(N_INPUT-1-i)*SIZE +: SIZE] = slot_in_r[i];
      pack_w_s[(N_INPUT-1-i)*SIZE +: SIZE]  = slot_w_r[i];
    end
  end

  // Fill stage: write the accepted pair into its slot, accumulate the weight, close the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_INPUT; i++) begin
        slot_in_r[i] <= '0;
        slot_w_r[i]  <= '0;
      end
      idx_r       <= '0;
      sum_r       <= '0;
      fill_done_r <= 1'b0;
      pad_r       <= 1'b0;
      s_ready_r   <= 1'b0;
    end else begin
      fill_done_r <= fill_done_nxt_s;
      // s_ready is registered from the next fill state, so m_ready never reaches it combinationally
      s_ready_r   <= !fill_done_nxt_s;
      if (xfer_s) begin
        for (int i = 0; i < N_INPUT; i++) begin
          slot_in_r[i] <= '0;
          slot_w_r[i]  <= '0;
        end
        idx_r <= '0;
        sum_r <= '0;
        pad_r <= 1'b0;
      end else if (accept_s) begin
        for (int i = 0; i < N_INPUT; i++) begin
          if (i == int'(idx_r)) begin
            slot_in_r[i] <= s_sample;
            slot_w_r[i]  <= s_weight;
          end else if (close_s && (i > int'(idx_r))) begin
            // A frame closed early by s_last gets zeros in the remaining slots.
            slot_in_r[i] <= '0;
            slot_w_r[i]  <= '0;
          end else begin
            slot_in_r[i] <= slot_in_r[i];
            slot_w_r[i]  <= slot_w_r[i];
          end
        end
        sum_r <= sum_r + WS_W'(s_weight);
        if (close_s) begin
          // A close that lands on the last slot is a full frame, even when s_last is set.
          pad_r <= (idx_r != LAST_IDX);
          idx_r <= '0;
        end else begin
          pad_r <= 1'b0;
          idx_r <= idx_r + IDX_W'(1'b1);
        end
      end else begin
        idx_r <= idx_r;
        sum_r <= sum_r;
        pad_r <= pad_r;
      end
    end
  end

  // Output stage: load a closed frame when it is free or draining, otherwise hold until accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid  <= 1'b0;
      m_in     <= '0;
      m_weight <= '0;
      m_wsum   <= '0;
      m_padded <= 1'b0;
    end else if (xfer_s) begin
      m_valid  <= 1'b1;
      m_in     <= pack_in_s;
      m_weight <= pack_w_s;
      m_wsum   <= sum_r;
      m_padded <= pad_r;
    end else if (m_valid && m_ready) begin
      m_valid  <= 1'b0;
    end else begin
      m_valid  <= m_valid;
    end
  end

  // Count delivered frames; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= 16'd0;
    end else if (m_valid && m_ready) begin
      frame_cnt <= frame_cnt + 16'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_weighted_mean_packer.sv
// Directed bench for weighted_mean_packer (N_INPUT=4, SIZE=32).
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled
// on the falling edge. A falling-edge monitor records every delivered frame.

module tb_weighted_mean_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_sample;
  logic [31:0]  s_weight;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_in;
  logic [127:0] m_weight;
  logic [33:0]  m_wsum;
  logic         m_padded;
  logic [15:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [127:0] got_in_q [$];
  logic [127:0] got_w_q  [$];
  logic [33:0]  got_ws_q [$];

  weighted_mean_packer #(.N_INPUT(4), .SIZE(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sample  (s_sample),
    .s_weight  (s_weight),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_in      (m_in),
    .m_weight  (m_weight),
    .m_wsum    (m_wsum),
    .m_padded  (m_padded),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Record each frame that will be handed over at the next rising edge.
  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      got_in_q.push_back(m_in);
      got_w_q.push_back(m_weight);
      got_ws_q.push_back(m_wsum);
    end
  end

  task automatic send_pair(input logic [31:0] smp, input logic [31:0] wt, input logic lst);
    int n;
    s_valid  = 1'b1;
    s_sample = smp;
    s_weight = wt;
    s_last   = lst;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept sample=%0d s_ready=%b expected 1 within 50 cycles", smp, s_ready);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b0; s_sample = 32'd0; s_weight = 32'd0; s_last = 1'b0; m_ready = 1'b0;
    #12;
    checks++;
    if ({m_valid, m_padded, s_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got valid/pad/ready=%b expected 000", {m_valid, m_padded, s_ready});
    end
    checks++;
    if ({m_in, m_weight} !== 256'd0) begin
      errors++; $display("FAIL reset_data got m_in=%h m_weight=%h expected 0", m_in, m_weight);
    end
    checks++;
    if ({m_wsum, frame_cnt} !== 50'd0) begin
      errors++; $display("FAIL reset_counts got wsum=%h frame_cnt=%0d expected 0", m_wsum, frame_cnt);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_early got %b expected 0", s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_late got %b expected 1", s_ready);
    end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_pair(32'd1, 32'd2, 1'b0);
    send_pair(32'd2, 32'd3, 1'b0);
    send_pair(32'd3, 32'd1, 1'b0);
    send_pair(32'd4, 32'd3, 1'b0);
    @(negedge clk);
    checks++;
    if ({m_valid, s_ready} !== 2'b00) begin
      errors++; $display("FAIL basic_latency_bubble got valid/ready=%b expected 00", {m_valid, s_ready});
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid got %b expected 1", m_valid);
    end
    checks++;
    if (m_in !== {32'd1, 32'd2, 32'd3, 32'd4} || m_weight !== {32'd2, 32'd3, 32'd1, 32'd3}) begin
      errors++; $display("FAIL basic_data got m_in=%h m_weight=%h", m_in, m_weight);
    end
    checks++;
    if (m_wsum !== 34'd9 || m_padded !== 1'b0) begin
      errors++; $display("FAIL basic_sum got wsum=%0d pad=%b expected 9/0", m_wsum, m_padded);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || frame_cnt !== 16'd1) begin
      errors++; $display("FAIL basic_dequeue got valid=%b frame_cnt=%0d expected 0/1", m_valid, frame_cnt);
    end
  endtask

  task automatic test_short();
    @(posedge clk); #1;
    send_pair(32'd5, 32'd1, 1'b0);
    send_pair(32'd6, 32'd2, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_in !== {32'd5, 32'd6, 32'd0, 32'd0} || m_weight !== {32'd1, 32'd2, 32'd0, 32'd0}) begin
      errors++; $display("FAIL short_data got valid=%b m_in=%h m_weight=%h", m_valid, m_in, m_weight);
    end
    checks++;
    if (m_wsum !== 34'd3 || m_padded !== 1'b1) begin
      errors++; $display("FAIL short_sum got wsum=%0d pad=%b expected 3/1", m_wsum, m_padded);
    end
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++; $display("FAIL short_cnt got %0d expected 2", frame_cnt);
    end
  endtask

  task automatic test_width();
    @(posedge clk); #1;
    send_pair(32'd11, 32'hFFFF_FFFF, 1'b0);
    send_pair(32'd12, 32'hFFFF_FFFF, 1'b0);
    send_pair(32'd13, 32'hFFFF_FFFF, 1'b0);
    send_pair(32'd14, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_wsum !== 34'h3_FFFF_FFFC) begin
      errors++; $display("FAIL width_sum got valid=%b wsum=%h expected 1/3fffffffc", m_valid, m_wsum);
    end
    checks++;
    if (m_padded !== 1'b0 || m_weight !== {4{32'hFFFF_FFFF}}) begin
      errors++; $display("FAIL width_pad got pad=%b m_weight=%h expected 0/all ones", m_padded, m_weight);
    end
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++; $display("FAIL width_cnt got %0d expected 3", frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a_in;
    logic [127:0] b_in;
    a_in = {32'd10, 32'd11, 32'd12, 32'd13};
    b_in = {32'd20, 32'd21, 32'd22, 32'd23};
    @(posedge clk); #1;
    m_ready = 1'b0;
    got_in_q.delete(); got_w_q.delete(); got_ws_q.delete();
    for (int i = 0; i < 8; i++) begin
      send_pair((i < 4) ? 32'(10 + i) : 32'(16 + i), 32'(i + 1), 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_in !== a_in || m_wsum !== 34'd10) begin
        errors++; $display("FAIL bp_hold cycle %0d got valid=%b ready=%b m_in=%h wsum=%0d", c, m_valid, s_ready, m_in, m_wsum);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_in !== b_in || m_wsum !== 34'd26 || s_ready !== 1'b1) begin
      errors++; $display("FAIL bp_b2b got valid=%b m_in=%h wsum=%0d ready=%b", m_valid, m_in, m_wsum, s_ready);
    end
    checks++;
    if (frame_cnt !== 16'd4 || got_in_q.size() != 1) begin
      errors++; $display("FAIL bp_count_a got frame_cnt=%0d delivered=%0d expected 4/1", frame_cnt, got_in_q.size());
    end else begin
      checks++;
      if (got_in_q[0] !== a_in) begin
        errors++; $display("FAIL bp_frame_a got %h expected %h", got_in_q[0], a_in);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || frame_cnt !== 16'd5 || got_in_q.size() != 2) begin
      errors++; $display("FAIL bp_drain got valid=%b frame_cnt=%0d delivered=%0d expected 0/5/2", m_valid, frame_cnt, got_in_q.size());
    end else begin
      checks++;
      if (got_in_q[1] !== b_in) begin
        errors++; $display("FAIL bp_frame_b got %h expected %h", got_in_q[1], b_in);
      end
    end
  endtask

  task automatic test_streaming();
    int acc;
    int cyc;
    int hi;
    int nxt;
    logic [127:0] exp_in;
    logic [127:0] exp_w;
    logic [33:0]  exp_ws;
    @(posedge clk); #1;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    got_in_q.delete(); got_w_q.delete(); got_ws_q.delete();
    acc = 0; cyc = 0; hi = 0; nxt = 1;
    s_valid = 1'b1; s_last = 1'b0;
    s_sample = 32'(nxt); s_weight = 32'(nxt % 5);
    while (acc < 200 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (s_ready) begin
        hi++;
        acc++;
        @(posedge clk); #1;
        if (acc < 200) begin
          nxt++;
          s_sample = 32'(nxt);
          s_weight = 32'(nxt % 5);
        end else begin
          s_valid = 1'b0;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (cyc != 249 || hi != 200) begin
      errors++; $display("FAIL stream_duty got cycles=%0d ready_cycles=%0d expected 249/200", cyc, hi);
    end
    checks++;
    if (frame_cnt !== 16'd50 || got_in_q.size() != 50) begin
      errors++; $display("FAIL stream_count got frame_cnt=%0d delivered=%0d expected 50/50", frame_cnt, got_in_q.size());
    end else begin
      for (int f = 0; f < 50; f++) begin
        exp_ws = 34'd0;
        for (int j = 0; j < 4; j++) begin
          exp_in[(3-j)*32 +: 32] = 32'(f*4 + 1 + j);
          exp_w[(3-j)*32 +: 32]  = 32'((f*4 + 1 + j) % 5);
          exp_ws = exp_ws + 34'((f*4 + 1 + j) % 5);
        end
        checks++;
        if (got_in_q[f] !== exp_in || got_w_q[f] !== exp_w || got_ws_q[f] !== exp_ws) begin
          errors++; $display("FAIL stream_frame %0d got in=%h w=%h ws=%0d expected in=%h w=%h ws=%0d",
                             f, got_in_q[f], got_w_q[f], got_ws_q[f], exp_in, exp_w, exp_ws);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    m_ready = 1'b0;
    send_pair(32'd40, 32'd1, 1'b0);
    send_pair(32'd41, 32'd1, 1'b0);
    send_pair(32'd42, 32'd1, 1'b0);
    send_pair(32'd43, 32'd1, 1'b0);
    send_pair(32'd44, 32'd1, 1'b0);
    send_pair(32'd45, 32'd1, 1'b0);
    #3;
    checks++;
    if (m_valid !== 1'b1 || m_in !== {32'd40, 32'd41, 32'd42, 32'd43}) begin
      errors++; $display("FAIL arst_before got valid=%b m_in=%h", m_valid, m_in);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_padded, s_ready} !== 3'b000 || {m_in, m_weight} !== 256'd0 ||
        m_wsum !== 34'd0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL arst_immediate got valid=%b ready=%b m_in=%h wsum=%0d frame_cnt=%0d",
                         m_valid, s_ready, m_in, m_wsum, frame_cnt);
    end
    #2;
    reset = 1'b1;
    m_ready = 1'b1;
    got_in_q.delete(); got_w_q.delete(); got_ws_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL arst_no_spurious got valid=%b expected 0", m_valid);
    end
    @(posedge clk); #1;
    send_pair(32'd50, 32'd1, 1'b0);
    send_pair(32'd51, 32'd2, 1'b0);
    send_pair(32'd52, 32'd3, 1'b0);
    send_pair(32'd53, 32'd4, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (got_in_q.size() != 1 || frame_cnt !== 16'd1) begin
      errors++; $display("FAIL arst_count got delivered=%0d frame_cnt=%0d expected 1/1", got_in_q.size(), frame_cnt);
    end else begin
      checks++;
      if (got_in_q[0] !== {32'd50, 32'd51, 32'd52, 32'd53} || got_ws_q[0] !== 34'd10) begin
        errors++; $display("FAIL arst_frame got in=%h ws=%0d expected 00000032..35/10", got_in_q[0], got_ws_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_width();
    test_backpressure();
    test_streaming();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
